// File: rtl/dec_pkg.sv
// Shared types and helpers for the registered 3-to-8 decoder.
package dec_pkg;

   localparam int DEC_IN_W  = 3;
   localparam int DEC_OUT_W = 8;

   typedef logic [DEC_IN_W-1:0]  dec_sel_t;
   typedef logic [DEC_OUT_W-1:0] dec_onehot_t;

   // Decode value with nothing asserted, before polarity is applied.
   localparam dec_onehot_t DEC_NONE = 8'h00;

   // Map an active-high decode onto the requested output polarity.
   function automatic dec_onehot_t apply_polarity(input dec_onehot_t d,
                                                  input logic        active_low);
      dec_onehot_t r;
      if (active_low) begin
         r = ~d;
      end else begin
         r = d;
      end
      return r;
   endfunction

endpackage : dec_pkg

// File: rtl/dec3to8_core.sv
// Purely combinational 3-to-8 one-hot decode with enable; no clock, no polarity.
module dec3to8_core
   import dec_pkg::*;
(
   input  dec_sel_t    a,
   input  logic        en,
   output dec_onehot_t d
);

   dec_onehot_t d_s;

   // Select the single asserted bit at position a, or nothing when disabled.
   always_comb begin
      d_s = DEC_NONE;
      if (en) begin
         case (a)
            3'd0:    d_s = 8'h01;
            3'd1:    d_s = 8'h02;
            3'd2:    d_s = 8'h04;
            3'd3:    d_s = 8'h08;
            3'd4:    d_s = 8'h10;
            3'd5:    d_s = 8'h20;
            3'd6:    d_s = 8'h40;
            3'd7:    d_s = 8'h80;
            default: d_s = DEC_NONE;
         endcase
      end else begin
         d_s = DEC_NONE;
      end
   end

   assign d = d_s;

endmodule : dec3to8_core

// File: rtl/dec_3to8.sv
// Registered 3-to-8 one-hot decoder with enable, selectable output polarity
// and a registered valid flag. Outputs come straight from flops.
module dec_3to8
   import dec_pkg::*;
#(
   parameter bit OUT_ACTIVE_LOW = 1'b0
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  a,
   input  logic        en,
   output logic [7:0]  s,
   output logic        s_valid
);

   // Idle level of the output bus in the configured polarity.
   localparam dec_onehot_t IDLE_PATTERN = apply_polarity(DEC_NONE, OUT_ACTIVE_LOW);

   dec_onehot_t d_s;
   dec_onehot_t d_pol_s;
   dec_onehot_t s_r;
   logic        s_valid_r;

   dec3to8_core u_core (
      .a  (a),
      .en (en),
      .d  (d_s)
   );

   assign d_pol_s = apply_polarity(d_s, OUT_ACTIVE_LOW);

   // Output register: reset forces idle and clears valid, otherwise load decode.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_r       <= IDLE_PATTERN;
         s_valid_r <= 1'b0;
      end else begin
         s_r       <= d_pol_s;
         s_valid_r <= en;
      end
   end

   assign s       = s_r;
   assign s_valid = s_valid_r;

endmodule : dec_3to8

// File: tb/tb_dec_3to8.sv
// Scoreboard bench for dec_3to8: active-high and active-low builds driven
// with the same directed vectors; expected responses queued by the driver
// and checked by an independent monitor one cycle later.
module tb_dec_3to8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b1;
   logic [2:0] a   = 3'd5;

   logic [7:0] s_hi;
   logic       v_hi;
   logic [7:0] s_lo;
   logic       v_lo;

   typedef struct packed {
      logic [7:0] hi;
      logic [7:0] lo;
      logic       v;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   dec_3to8 #(.OUT_ACTIVE_LOW(1'b0)) u_dut_hi (
      .clk(clk), .rst(rst), .a(a), .en(en), .s(s_hi), .s_valid(v_hi)
   );

   dec_3to8 #(.OUT_ACTIVE_LOW(1'b1)) u_dut_lo (
      .clk(clk), .rst(rst), .a(a), .en(en), .s(s_lo), .s_valid(v_lo)
   );

   // Drive one vector for the next rising edge and queue its expected response.
   task automatic step(input logic r, input logic e, input logic [2:0] sel,
                       input logic [7:0] hi, input logic [7:0] lo, input logic v);
      @(negedge clk);
      rst = r;
      en  = e;
      a   = sel;
      exp_q.push_back({hi, lo, v});
   endtask

   // Monitor: after every rising edge, pop one expectation and compare both builds.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (s_hi !== e.hi) begin
               errors++;
               $display("FAIL s_hi t=%0t got=%h want=%h", $time, s_hi, e.hi);
            end
            checks++;
            if (v_hi !== e.v) begin
               errors++;
               $display("FAIL valid_hi t=%0t got=%b want=%b", $time, v_hi, e.v);
            end
            checks++;
            if (s_lo !== e.lo) begin
               errors++;
               $display("FAIL s_lo t=%0t got=%h want=%h", $time, s_lo, e.lo);
            end
            checks++;
            if (v_lo !== e.v) begin
               errors++;
               $display("FAIL valid_lo t=%0t got=%b want=%b", $time, v_lo, e.v);
            end
         end
      end
   end

   // Watchdog so the run always terminates.
   initial begin
      #100000;
      errors++;
      checks++;
      $display("FAIL timeout t=%0t pending=%0d want=0", $time, exp_q.size());
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Directed stimulus: rst, en, a, expected s (active-high), s (active-low), s_valid.
   initial begin
      // Reset held two cycles with en=1, a=5.
      step(1'b1, 1'b1, 3'd5, 8'h00, 8'hFF, 1'b0);
      step(1'b1, 1'b1, 3'd5, 8'h00, 8'hFF, 1'b0);
      // Disabled, then disabled with an unknown select.
      step(1'b0, 1'b0, 3'd0,   8'h00, 8'hFF, 1'b0);
      step(1'b0, 1'b0, 3'bxxx, 8'h00, 8'hFF, 1'b0);
      // Full sweep, back to back.
      step(1'b0, 1'b1, 3'd0, 8'h01, 8'hFE, 1'b1);
      step(1'b0, 1'b1, 3'd1, 8'h02, 8'hFD, 1'b1);
      step(1'b0, 1'b1, 3'd2, 8'h04, 8'hFB, 1'b1);
      step(1'b0, 1'b1, 3'd3, 8'h08, 8'hF7, 1'b1);
      step(1'b0, 1'b1, 3'd4, 8'h10, 8'hEF, 1'b1);
      step(1'b0, 1'b1, 3'd5, 8'h20, 8'hDF, 1'b1);
      step(1'b0, 1'b1, 3'd6, 8'h40, 8'hBF, 1'b1);
      step(1'b0, 1'b1, 3'd7, 8'h80, 8'h7F, 1'b1);
      // Enable drop: no hold-over of the previous decode.
      step(1'b0, 1'b0, 3'd7, 8'h00, 8'hFF, 1'b0);
      // Resume, then reset mid-sweep with a=4, release with a=6.
      step(1'b0, 1'b1, 3'd3, 8'h08, 8'hF7, 1'b1);
      step(1'b1, 1'b1, 3'd4, 8'h00, 8'hFF, 1'b0);
      step(1'b0, 1'b1, 3'd6, 8'h40, 8'hBF, 1'b1);
      // Polarity spot checks and non-monotonic select changes.
      step(1'b0, 1'b1, 3'd2, 8'h04, 8'hFB, 1'b1);
      step(1'b0, 1'b0, 3'd2, 8'h00, 8'hFF, 1'b0);
      step(1'b0, 1'b1, 3'd5, 8'h20, 8'hDF, 1'b1);
      step(1'b0, 1'b1, 3'd1, 8'h02, 8'hFD, 1'b1);
      step(1'b0, 1'b1, 3'd7, 8'h80, 8'h7F, 1'b1);
      step(1'b0, 1'b1, 3'd0, 8'h01, 8'hFE, 1'b1);
      step(1'b0, 1'b0, 3'd4, 8'h00, 8'hFF, 1'b0);
      // Let the monitor drain the last expectation.
      repeat (2) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d want=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_dec_3to8
